// File: rtl/kbd_pkg.sv
// Shared constants for the keyboard FIFO: default sizes, status-bit offsets and
// the word returned by a read of an empty FIFO.
package kbd_pkg;

  localparam int unsigned DATA_W_DEF = 7;
  localparam int unsigned DEPTH_DEF  = 8;
  localparam int unsigned OUT_W_DEF  = 16;

  // Status bit offsets for the default bus width.
  localparam int unsigned VALID_BIT = OUT_W_DEF - 1;
  localparam int unsigned OVF_BIT   = OUT_W_DEF - 2;

  // A read that finds no key returns all zeros.
  localparam logic [OUT_W_DEF-1:0] EMPTY_READ = '0;

  // Status bit offsets for an arbitrary bus width.
  function automatic int unsigned valid_bit(int unsigned out_w);
    return out_w - 1;
  endfunction

  function automatic int unsigned ovf_bit(int unsigned out_w);
    return out_w - 2;
  endfunction

endpackage

// File: rtl/kbd_fifo_mem.sv
// DEPTH x DATA_W register array for the keyboard FIFO: synchronous write,
// asynchronous read. Contents are not reset.
module kbd_fifo_mem #(
  parameter int unsigned DATA_W = 7,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Store the pushed key at the write address.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/keyboard_fifo.sv
// Keyboard key FIFO: pushes a key code on each rising edge of the key strobe and
// returns keys on a registered bus word when out_en is high. A push into a full
// FIFO with no simultaneous pop is dropped and sets a sticky overflow flag.
// Optional build macro KEYBOARD_FIFO_STATUS_EN adds valid/overflow status bits
// to the top of every read word that returns data.
module keyboard_fifo
  import kbd_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W:0]   in,
  input  logic              out_en,
  output logic [OUT_W-1:0]  out,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_strobe_prev;
  logic              r_overflow;
  logic [OUT_W-1:0]  r_out;

  logic              w_push_req;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [CW-1:0]     w_count_d;
  logic [DATA_W-1:0] w_rd_data;
  logic [OUT_W-1:0]  w_read_word;

  assign empty    = (r_count == '0);
  assign full     = (r_count == CW'(DEPTH));
  assign overflow = r_overflow;
  assign out      = r_out;

  // A held strobe pushes once: only a 0->1 transition counts.
  assign w_push_req = in[DATA_W] & ~r_strobe_prev;
  assign w_pop      = out_en & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push     = w_push_req & (~full | w_pop);
  assign w_drop     = w_push_req & full & ~w_pop;

  kbd_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (in[DATA_W-1:0]),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  // Next occupancy from the push/pop combination.
  always_comb begin
    w_count_d = r_count;
    if (w_push && !w_pop) begin
      w_count_d = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_d = r_count - CW'(1);
    end
  end

`ifdef KEYBOARD_FIFO_STATUS_EN
  localparam int unsigned ValidBit = valid_bit(OUT_W);
  localparam int unsigned OvfBit   = ovf_bit(OUT_W);

  // Head code plus valid flag and the overflow flag as it stood before the pop.
  always_comb begin
    w_read_word                 = OUT_W'(EMPTY_READ);
    w_read_word[DATA_W-1:0]     = w_rd_data;
    w_read_word[ValidBit]       = 1'b1;
    w_read_word[OvfBit]         = r_overflow;
  end
`else
  // Head code, zero-extended to the bus width.
  always_comb begin
    w_read_word             = OUT_W'(EMPTY_READ);
    w_read_word[DATA_W-1:0] = w_rd_data;
  end
`endif

  // Pointers, count, strobe history, overflow flag and the registered read word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_strobe_prev <= 1'b0;
      r_overflow    <= 1'b0;
      r_out         <= '0;
    end else begin
      r_strobe_prev <= in[DATA_W];
      r_count       <= w_count_d;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      // A fresh drop wins over the clear from a successful pop.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (w_pop) begin
        r_overflow <= 1'b0;
      end
      if (out_en) begin
        r_out <= w_pop ? w_read_word : OUT_W'(EMPTY_READ);
      end
    end
  end

endmodule
